// File: rtl/div_controller.sv
// Sequencing FSM for the 16-bit repeated-subtraction divider datapath.
// Drives Clear/Load/IncQ strobes and reports completion, divide-by-zero and overflow.
module div_controller #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  input  logic              PgtN,
  input  logic              PeqN,
  output logic              LoadN,
  output logic              LoadS,
  output logic              LoadP,
  output logic              Clear,
  output logic              IncQ,
  output logic              busy,
  output logic              done,
  output logic [1:0]        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LDN,
    S_LDP,
    S_CALC,
    S_DONE
  } state_t;

  typedef enum logic [1:0] {
    ERR_OK   = 2'b00,
    ERR_DIV0 = 2'b01,
    ERR_OVF  = 2'b10
  } err_t;

  state_t            r_state;
  err_t              r_err;
  logic              r_busy;
  logic [ITER_W-1:0] r_cnt;

  logic w_cont;
  logic w_at_max;
  logic w_zero_div;

  assign w_cont     = PgtN | PeqN;
  assign w_at_max   = (r_cnt == ITER_W'(MAX_ITER));
  assign w_zero_div = (data_in == '0);

  assign busy = r_busy;
  assign err  = r_err;

  // Strobes are decoded from the current state and live inputs, not registered.
  always_comb begin
    Clear    = 1'b0;
    LoadN    = 1'b0;
    LoadS    = 1'b0;
    LoadP    = 1'b0;
    IncQ     = 1'b0;
    in_ready = 1'b0;
    done     = 1'b0;
    case (r_state)
      S_CLR: Clear = 1'b1;
      S_LDN: begin
        in_ready = 1'b1;
        LoadN    = in_valid;
      end
      S_LDP: begin
        in_ready = 1'b1;
        LoadP    = in_valid;
      end
      S_CALC: begin
        if (w_cont && !w_at_max) begin
          LoadN = 1'b1;
          LoadS = 1'b1;
          IncQ  = 1'b1;
        end
      end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_err   <= ERR_OK;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_CLR;
            r_busy  <= 1'b1;
            r_err   <= ERR_OK;
          end
        end
        S_CLR: begin
          r_cnt   <= '0;
          r_state <= S_LDN;
        end
        S_LDN: begin
          if (in_valid) r_state <= S_LDP;
        end
        S_LDP: begin
          if (in_valid) begin
            if (w_zero_div) begin
              r_err   <= ERR_DIV0;
              r_state <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          // Counter saturates at MAX_ITER: hitting it with the loop still live aborts.
          if (w_cont) begin
            if (w_at_max) begin
              r_err   <= ERR_OVF;
              r_state <= S_DONE;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_controller.sv
// Directed bench for div_controller with a behavioural model of the divider datapath.
module tb_div_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_in;
  logic        PgtN, PeqN;
  logic        LoadN, LoadS, LoadP, Clear, IncQ;
  logic        busy, done;
  logic [1:0]  err;

  logic [15:0] dp_n, dp_p;
  logic [7:0]  dp_q;
  logic        peq_en;

  int total;
  int bad;
  int viol;

  always #5 clk = ~clk;

  div_controller #(
    .DATA_W  (16),
    .ITER_W  (8),
    .MAX_ITER(255)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_in (data_in),
    .PgtN    (PgtN),
    .PeqN    (PeqN),
    .LoadN   (LoadN),
    .LoadS   (LoadS),
    .LoadP   (LoadP),
    .Clear   (Clear),
    .IncQ    (IncQ),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  // Datapath model: N, P, Q registers plus combinational compare.
  assign PgtN = (dp_n > dp_p);
  assign PeqN = peq_en & (dp_n == dp_p);

  always @(posedge clk) begin
    if (Clear) begin
      dp_n <= '0;
      dp_p <= '0;
      dp_q <= '0;
    end else begin
      if (LoadN) dp_n <= LoadS ? dp_n - dp_p : data_in;
      if (LoadP) dp_p <= data_in;
      if (IncQ)  dp_q <= dp_q + 8'd1;
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          peq;
    int          sn;
    int          sp;
    bit          hold;
    int          q;
    int          n;
    int          e;
    int          lat;
    int          inc;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Runs one operation; latency is counted in cycles after the start-sampling edge.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input bit peq,
                       input int sn, input int sp, input bit hold, input int abort_at,
                       output int lat, output int inc, output int err_at_done);
    int  cyc;
    int  phase;
    int  stall;
    bit  hs;
    peq_en      = peq;
    lat         = -1;
    inc         = 0;
    err_at_done = -1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    cyc   = 1;
    phase = 0;
    stall = sn;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cyc == abort_at) begin
        rst      = 1'b1;
        in_valid = 1'b0;
        start    = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        return;
      end
      if (cyc == 1) begin
        chk("clear_pulse", int'(Clear), 1);
        chk("busy_set", int'(busy), 1);
        chk("err_cleared", int'(err), 0);
      end
      if (done) begin
        lat         = cyc;
        err_at_done = int'(err);
        chk("busy_at_done", int'(busy), 1);
        start    = 1'b0;
        in_valid = 1'b0;
        break;
      end
      if (in_ready && phase < 2) begin
        if (stall > 0) begin
          in_valid = 1'b0;
          stall--;
        end else begin
          in_valid = 1'b1;
          data_in  = (phase == 0) ? a : b;
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (Clear && (LoadN || LoadS || LoadP || IncQ)) viol++;
      if (LoadS && !LoadN) viol++;
      if (IncQ) inc++;
      hs = in_valid && in_ready;
      @(posedge clk);
      if (hs) begin
        phase++;
        stall = sp;
      end
      #1;
      in_valid = 1'b0;
      cyc++;
    end
    if (lat < 0) begin
      chk("op_timeout", 0, 1);
    end else begin
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("busy_fall", int'(busy), 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat, inc, ed;
    do_op(v.a, v.b, v.peq, v.sn, v.sp, v.hold, -1, lat, inc, ed);
    $display("vector %0d: %0d / %0d latency=%0d", idx, v.a, v.b, lat);
    chk("latency", lat, v.lat);
    chk("incq_pulses", inc, v.inc);
    chk("quotient", int'(dp_q), v.q);
    chk("remainder", int'(dp_n), v.n);
    chk("err_at_done", ed, v.e);
    chk("err_held", int'(err), v.e);
  endtask

  initial begin
    int lat, inc, ed;
    total    = 0;
    bad      = 0;
    viol     = 0;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;
    peq_en   = 1'b1;

    // a, b, peq, stallN, stallP, hold start, Q, N, err, latency, IncQ pulses
    vecs[0]  = '{16'd17,    16'd5, 1'b1, 0, 0, 1'b0,   3,     2, 0,  8,   3};
    vecs[1]  = '{16'd10,    16'd5, 1'b1, 0, 0, 1'b0,   2,     0, 0,  7,   2};
    vecs[2]  = '{16'd10,    16'd5, 1'b0, 0, 0, 1'b0,   1,     5, 0,  6,   1};
    vecs[3]  = '{16'd3,     16'd7, 1'b1, 0, 0, 1'b0,   0,     3, 0,  5,   0};
    vecs[4]  = '{16'd9,     16'd0, 1'b1, 0, 0, 1'b0,   0,     9, 1,  4,   0};
    vecs[5]  = '{16'd65535, 16'd1, 1'b1, 0, 0, 1'b0, 255, 65280, 2, 260, 255};
    vecs[6]  = '{16'd17,    16'd5, 1'b1, 3, 2, 1'b0,   3,     2, 0, 13,   3};
    vecs[7]  = '{16'd0,     16'd5, 1'b1, 0, 0, 1'b0,   0,     0, 0,  5,   0};
    vecs[8]  = '{16'd5,     16'd5, 1'b1, 0, 0, 1'b0,   1,     0, 0,  6,   1};
    vecs[9]  = '{16'd5,     16'd5, 1'b0, 0, 0, 1'b0,   0,     5, 0,  5,   0};
    vecs[10] = '{16'd100,   16'd1, 1'b1, 0, 0, 1'b1, 100,     0, 0, 105, 100};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outputs",
        int'({busy, done, in_ready, err, LoadN, LoadS, LoadP, Clear, IncQ}), 0);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset in the middle of a long CALC run, then a clean operation.
    do_op(16'd65535, 16'd1, 1'b1, 0, 0, 1'b0, 20, lat, inc, ed);
    @(negedge clk);
    chk("rst_mid_calc_outputs",
        int'({busy, done, in_ready, err, LoadN, LoadS, LoadP, Clear, IncQ}), 0);
    run_vec(vecs[0], 0);

    chk("strobe_rules", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_controller.md
# div_controller

Sequencing FSM for the 16-bit repeated-subtraction divider datapath. It accepts a start request and two operands over a valid/ready handshake, then drives the datapath's `Clear`, `LoadN`, `LoadS`, `LoadP` and `IncQ` strobes. It iterates subtract-and-increment until the compare flags terminate the loop. It reports completion, divide-by-zero and iteration overflow to the surrounding system.

## Interface
- `DATA_W`, 16, operand/bus width; matches datapath `Data_in`
- `ITER_W`, 8, iteration counter width; matches datapath quotient register
- `MAX_ITER`, 255, maximum subtract iterations before overflow abort

- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request a division; sampled only in IDLE
- `in_valid`  in  1  operand word present on `data_in`
- `in_ready`  out  1  controller accepts operand this cycle
- `data_in`  in  DATA_W  operand bus; same wires as datapath `Data_in`; observed only for the zero-divisor check
- `PgtN`  in  1  datapath compare: N register > P register
- `PeqN`  in  1  datapath compare: N register == P register; tie 0 for strict-greater loop
- `LoadN`, `LoadS`, `LoadP`, `Clear`, `IncQ`  out  1 each  datapath strobes
- `busy`  out  1  high from start acceptance until DONE exits
- `done`  out  1  one-cycle completion pulse
- `err`  out  2  00 ok, 01 divide-by-zero, 10 iteration overflow; held until next start

## Operation
- States: IDLE, CLR, LDN, LDP, CALC, DONE.
- IDLE:
  - `start`=1 → CLR, `busy`←1, `err`←00.
  - `start` is ignored in every other state.
- CLR:
  - `Clear`=1 for exactly one cycle; iteration counter ←0.
  - → LDN.
- LDN:
  - `in_ready`=1.
  - On `in_valid`: `LoadN`=1, `LoadS`=0 (dividend loaded from bus), → LDP.
  - Otherwise wait indefinitely.
- LDP:
  - `in_ready`=1.
  - On `in_valid`: `LoadP`=1.
  - If `data_in`==0: `err`←01, → DONE.
  - Otherwise → CALC.
- CALC (one cycle per iteration); `cont` = `PgtN` | `PeqN`:
  - `cont`=1 and counter < MAX_ITER: `LoadN`=1, `LoadS`=1 (N ← N−P), `IncQ`=1, counter+1, stay in CALC.
  - `cont`=1 and counter == MAX_ITER: no strobes, `err`←10, → DONE.
  - `cont`=0: no strobes, → DONE; quotient in datapath Q, remainder in N.
- DONE: `done`=1 for one cycle, `busy`←0, → IDLE.
- Strobe rules:
  - All strobes are Moore/Mealy outputs of the current state and inputs, not registered.
  - `Clear` is never asserted together with `IncQ` or any Load strobe.
  - `LoadS` is 0 whenever `LoadN`=0.
- Counter: ITER_W bits; never exceeds MAX_ITER, so it never wraps.
- `rst` in any state:
  - Next state IDLE; `busy`, `done`, `in_ready`, all strobes ←0; `err`←00.
  - Datapath contents are left stale; the next operation's CLR cleans them.

## Timing
- Reset values: `busy`=0, `done`=0, `in_ready`=0, `err`=00, `LoadN`=`LoadS`=`LoadP`=`Clear`=`IncQ`=0.
- `start` sampled high at edge T: CLR occupies cycle T+1; LDN from T+2.
- Zero-stall operand phase: dividend accepted at T+2, divisor at T+3, CALC from T+4.
- Flags are first valid in CALC: P loads at the T+3→T+4 edge and the compare is combinational.
- Quotient q (q ≤ MAX_ITER): CALC lasts q+1 cycles; `done` high in cycle T+5+q; `busy` falls the cycle after `done`.
- Divide-by-zero: `done` in T+4 (zero stalls); no CALC cycles.
- Each `in_valid` low cycle in LDN/LDP adds exactly one cycle.
- An `in_valid`&`in_ready` handshake consumes exactly one word.

## Test plan
- Dividend 17, divisor 5, `PeqN` wired, no stalls → 3 cycles of `IncQ`; Q=3, N=2; `done` at T+8; `err`=00.
- Dividend 10, divisor 5, `PeqN` wired → Q=2, N=0. Same operands with `PeqN` tied 0 → Q=1, N=5.
- Dividend 3, divisor 7 → zero `IncQ` pulses; Q=0, N=3; `done` at T+5.
- Divisor 0 → `LoadP` pulse; `err`=01, `done` at T+4; no `IncQ`; next start clears `err`.
- Dividend 65535, divisor 1 → exactly 255 `IncQ` pulses, then `err`=10; Q=255.
- `in_valid` low 3 cycles in LDN and 2 in LDP → `done` delayed by 5 cycles. Also:
  - `start` during CALC is ignored.
  - `rst` mid-CALC → all outputs 0 next cycle; a new 17/5 operation completes correctly.
